// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge: FSM state encoding,
// captured response record and the default bus geometry / wait-state timeout.
package apb_master_pkg;

  localparam int APB_ADDR_WIDTH     = 16;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      error;
    logic                      timeout;
  } apb_rsp_t;

  // A disabled timeout (0) still needs a one-bit counter to keep the type legal.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB3 requester signals of the bridge.
// master = the bridge itself, slave = the environment (command source and APB completer).
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = apb_master_pkg::APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_master_pkg::APB_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. expired is high during the enabled cycle that
// is the TIMEOUT_CYCLES-th since clear; never asserts when TIMEOUT_CYCLES is 0.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = timer_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      logic [CW-1:0] count;

      always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && (count != CW'(TIMEOUT_CYCLES))) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer and
// returns data/error/timeout on a valid/ready response channel. One transfer outstanding.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a command
//   SETUP  | PSELx high, PENABLE low, wait timer cleared
//   ACCESS | PSELx and PENABLE high, waiting for PREADY or timeout
//   RESP   | response held on rsp_* until consumer takes it
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);

  apb_mst_state_e        state;
  logic                  req_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  apb_rsp_t              rsp_q;
  logic                  timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_sys (PCLK),
    .rst_b   (PRESETn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !bus.PREADY),
    .expired (timer_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            pwrite_q    <= bus.req_write;
            paddr_q     <= bus.req_addr;
            pwdata_q    <= bus.req_wdata;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a timeout landing in the same cycle.
          if (bus.PREADY) begin
            rsp_q.rdata   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_q.error   <= bus.PSLVERR;
            rsp_q.timeout <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (timer_expired) begin
            rsp_q.rdata   <= '0;
            rsp_q.error   <= 1'b1;
            rsp_q.timeout <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_error   = rsp_q.error;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge with an 8-cycle timeout: directed scenarios plus
// randomized transfers checked against a transfer-level latency/response model.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int            obs_lat;
  logic          obs_ready_in;
  bit            obs_phase_ok;
  bit            obs_req_blocked;
  bit            obs_hold_ok;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  logic          obs_to;
  logic          obs_post_valid;
  logic          obs_post_ready;

  // Transfer-level model: waits = ACCESS cycles with PREADY low before it rises.
  function automatic int model_lat(input int waits);
    int access;
    access = (TO != 0 && waits >= TO) ? TO : waits + 1;
    return 2 + access;
  endfunction

  function automatic logic [DW+1:0] model_rsp(input bit wr, input int waits,
                                              input logic [DW-1:0] rdata, input bit slverr);
    if (TO != 0 && waits >= TO) return {{DW{1'b0}}, 2'b11};
    return {(wr ? {DW{1'b0}} : rdata), slverr, 1'b0};
  endfunction

  task automatic drive_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input int waits, input logic [DW-1:0] rdata, input bit slverr,
                            input int hold);
    @(negedge clk);
    obs_ready_in  = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = DW'($urandom);
    bus.PSLVERR   = ~slverr;
    obs_lat = -1; obs_phase_ok = 1'b1; obs_req_blocked = 1'b1; obs_hold_ok = 1'b1;
    for (int k = 1; k <= 40 && obs_lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
      end
      if (bus.rsp_valid === 1'b1) begin
        obs_lat = k;
      end else begin
        if (bus.PSELx !== 1'b1 || bus.PENABLE !== (k > 1) || bus.PADDR !== addr ||
            bus.PWRITE !== wr || bus.PWDATA !== wdata) obs_phase_ok = 1'b0;
        if (bus.req_ready !== 1'b0) obs_req_blocked = 1'b0;
        if (k > 1 && (k - 1) > waits) begin
          bus.PREADY = 1'b1; bus.PRDATA = rdata; bus.PSLVERR = slverr;
        end else begin
          bus.PREADY  = (k == 1) ? 1'($urandom) : 1'b0;
          bus.PRDATA  = DW'($urandom);
          bus.PSLVERR = ~slverr;
        end
      end
    end
    bus.PREADY = 1'b0; bus.PRDATA = DW'($urandom); bus.PSLVERR = 1'($urandom);
    obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_error; obs_to = bus.rsp_timeout;
    if (bus.PSELx !== 1'b0 || bus.PENABLE !== 1'b0 || bus.req_ready !== 1'b0) obs_phase_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== obs_rdata || bus.rsp_error !== obs_err ||
          bus.rsp_timeout !== obs_to || bus.req_ready !== 1'b0 || bus.PSELx !== 1'b0 ||
          bus.PADDR !== addr || bus.PWDATA !== wdata) obs_hold_ok = 1'b0;
      bus.PREADY = 1'($urandom); bus.PRDATA = DW'($urandom); bus.PSLVERR = 1'($urandom);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    obs_post_valid = bus.rsp_valid;
    obs_post_ready = bus.req_ready;
    if (bus.PADDR !== addr || bus.PWRITE !== wr) obs_hold_ok = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready);
    end
    total++;
    if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000",
        {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout});
    end
    total++;
    if (bus.PADDR !== '0 || bus.PWDATA !== '0 || bus.rsp_rdata !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    drive_xfer(1'b1, AW'(16'h0000), DW'(32'hA5), 0, DW'(32'hDEAD_BEEF), 1'b0, 0);
    total++;
    if (obs_ready_in !== 1'b1) begin bad++; $display("FAIL write_ready_in got=%b want=1", obs_ready_in); end
    total++;
    if (obs_lat !== 3) begin bad++; $display("FAIL write_latency got=%0d want=3", obs_lat); end
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {{DW{1'b0}}, 2'b00}) begin
      bad++; $display("FAIL write_rsp got=%h/%b/%b want=0/0/0", obs_rdata, obs_err, obs_to);
    end
    total++;
    if (!obs_phase_ok || !obs_req_blocked) begin
      bad++; $display("FAIL write_phases got=%b%b want=11", obs_phase_ok, obs_req_blocked);
    end
    total++;
    if ({obs_post_valid, obs_post_ready} !== 2'b01) begin
      bad++; $display("FAIL write_release got=%b%b want=01", obs_post_valid, obs_post_ready);
    end
  endtask

  task automatic test_read_wait();
    drive_xfer(1'b0, AW'(16'h0004), DW'($urandom), 3, DW'(32'h5A), 1'b0, 1);
    total++;
    if (obs_lat !== 6) begin bad++; $display("FAIL read_wait_latency got=%0d want=6", obs_lat); end
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {DW'(32'h5A), 2'b00}) begin
      bad++; $display("FAIL read_wait_rsp got=%h/%b/%b want=5a/0/0", obs_rdata, obs_err, obs_to);
    end
    total++;
    if (!obs_phase_ok || !obs_hold_ok) begin
      bad++; $display("FAIL read_wait_addr_stable got=%b%b want=11", obs_phase_ok, obs_hold_ok);
    end
  endtask

  task automatic test_slverr();
    logic [DW-1:0] d;
    d = DW'($urandom);
    drive_xfer(1'b0, AW'(16'h0008), DW'($urandom), 2, d, 1'b1, 0);
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {d, 2'b10} || obs_lat !== 5) begin
      bad++; $display("FAIL slverr_rsp got=%h/%b/%b lat=%0d want=%h/1/0 lat=5", obs_rdata, obs_err, obs_to, obs_lat, d);
    end
    // PSLVERR held high during the wait states must not leak into the response
    d = DW'($urandom);
    drive_xfer(1'b0, AW'(16'h000C), DW'($urandom), 3, d, 1'b0, 0);
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {d, 2'b00}) begin
      bad++; $display("FAIL slverr_ignored got=%h/%b/%b want=%h/0/0", obs_rdata, obs_err, obs_to, d);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    drive_xfer(1'b0, AW'(16'h0010), DW'($urandom), 30, DW'($urandom), 1'b0, 0);
    total++;
    if (obs_lat !== 2 + TO) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", obs_lat, 2 + TO); end
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {{DW{1'b0}}, 2'b11}) begin
      bad++; $display("FAIL timeout_rsp got=%h/%b/%b want=0/1/1", obs_rdata, obs_err, obs_to);
    end
    d = DW'($urandom);
    drive_xfer(1'b0, AW'(16'h0014), DW'($urandom), TO - 1, d, 1'b0, 0);
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {d, 2'b00} || obs_lat !== 2 + TO) begin
      bad++; $display("FAIL timeout_ready_wins got=%h/%b/%b lat=%0d want=%h/0/0 lat=%0d",
        obs_rdata, obs_err, obs_to, obs_lat, d, 2 + TO);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    logic [DW-1:0] d;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = AW'(16'h0020);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.PREADY = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.PSELx, bus.PENABLE} !== 2'b11) begin
      bad++; $display("FAIL reset_mid_in_access got=%b%b want=11", bus.PSELx, bus.PENABLE);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.req_ready} !== 4'b0001) begin
      bad++; $display("FAIL reset_mid_async got=%b want=0001",
        {bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.PREADY = 1'b1; bus.PRDATA = DW'($urandom);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.PSELx !== 1'b0 || bus.req_ready !== 1'b1) quiet = 1'b0;
    end
    bus.PREADY = 1'b0;
    total++;
    if (!quiet) begin bad++; $display("FAIL reset_mid_no_rsp got=%b want=1", quiet); end
    d = DW'($urandom);
    drive_xfer(1'b0, AW'(16'h0024), DW'($urandom), 1, d, 1'b0, 0);
    total++;
    if ({obs_rdata, obs_err, obs_to} !== {d, 2'b00} || obs_lat !== 4) begin
      bad++; $display("FAIL reset_mid_recover got=%h/%b/%b lat=%0d want=%h/0/0 lat=4",
        obs_rdata, obs_err, obs_to, obs_lat, d);
    end
  endtask

  task automatic test_backpressure();
    drive_xfer(1'b1, AW'(16'h0030), DW'($urandom), 1, DW'($urandom), 1'b0, 5);
    total++;
    if (!obs_hold_ok) begin bad++; $display("FAIL backpressure_stable got=%b want=1", obs_hold_ok); end
    total++;
    if ({obs_post_valid, obs_post_ready} !== 2'b01 || obs_lat !== 4) begin
      bad++; $display("FAIL backpressure_release got=%b%b lat=%0d want=01 lat=4",
        obs_post_valid, obs_post_ready, obs_lat);
    end
  endtask

  task automatic test_back_to_back();
    localparam int HOLD = 5;
    int rsp_seen, first_psel, b_seen;
    logic [DW-1:0] bval;
    logic [AW-1:0] baddr;
    bval = DW'($urandom); baddr = AW'($urandom);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'(16'h0040); bus.req_wdata = DW'($urandom);
    bus.PREADY = 1'b1; bus.PRDATA = bval; bus.PSLVERR = 1'b0; bus.rsp_ready = 1'b0;
    rsp_seen = -1; first_psel = -1;
    for (int c = 1; c <= 30 && first_psel < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.req_write = 1'b0; bus.req_addr = baddr; end
      if (bus.rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = c;
      if (rsp_seen > 0 && c > rsp_seen && bus.PSELx === 1'b1) first_psel = c;
      bus.rsp_ready = (rsp_seen > 0 && c == rsp_seen + HOLD);
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    total++;
    if (rsp_seen !== 3) begin bad++; $display("FAIL b2b_first_rsp got=%0d want=3", rsp_seen); end
    total++;
    if (first_psel !== 3 + HOLD + 2) begin
      bad++; $display("FAIL b2b_second_accept got=%0d want=%0d", first_psel, 3 + HOLD + 2);
    end
    b_seen = 0;
    for (int c = 0; c < 10 && b_seen == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) b_seen = c + 1;
    end
    total++;
    if (b_seen !== 2 || bus.rsp_rdata !== bval || bus.PADDR !== baddr) begin
      bad++; $display("FAIL b2b_second_rsp got=%0d/%h/%h want=2/%h/%h", b_seen, bus.rsp_rdata, bus.PADDR, bval, baddr);
    end
    bus.rsp_ready = 1'b1; bus.PREADY = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    bit wr, se;
    int waits, hold, exp_lat;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [DW+1:0] exp_rsp;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom); se = 1'($urandom);
      waits = $urandom_range(0, TO + 3); hold = $urandom_range(0, 3);
      a = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
      exp_lat = model_lat(waits);
      exp_rsp = model_rsp(wr, waits, rd, se);
      drive_xfer(wr, a, wd, waits, rd, se, hold);
      total++;
      if (obs_lat !== exp_lat || {obs_rdata, obs_err, obs_to} !== exp_rsp) begin
        bad++; $display("FAIL random_%0d got=lat %0d rsp %h want=lat %0d rsp %h",
          n, obs_lat, {obs_rdata, obs_err, obs_to}, exp_lat, exp_rsp);
      end
      total++;
      if (!obs_phase_ok || !obs_req_blocked || !obs_hold_ok || {obs_post_valid, obs_post_ready} !== 2'b01) begin
        bad++; $display("FAIL random_bus_%0d got=%b%b%b%b%b want=11101", n,
          obs_phase_ok, obs_req_blocked, obs_hold_ok, obs_post_valid, obs_post_ready);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
